// File: rtl/fft_peak_pkg.sv
// Shared types and default sizing for the FFT peak tracker.
package fft_peak_pkg;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 12;
  localparam int DEF_N_BINS = 256;
endpackage

// File: rtl/fft_peak_cmp.sv
// Running-maximum register: load seeds the max, en folds in a new bin (strictly greater wins).
// nxt_* expose the post-update value so the final beat can be captured in the same cycle.
module fft_peak_cmp #(
  parameter int DATA_W = 12,
  parameter int IDX_W  = 8
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              load,
  input  logic              en,
  input  logic [DATA_W-1:0] mag,
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] nxt_mag,
  output logic [IDX_W-1:0]  nxt_idx
);
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  always_comb begin
    mag_d = mag_q;
    idx_d = idx_q;
    if (load) begin
      mag_d = mag;
      idx_d = idx;
    end else if (en && (mag > mag_q)) begin
      mag_d = mag;
      idx_d = idx;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      mag_q <= '0;
      idx_q <= '0;
    end else begin
      mag_q <= mag_d;
      idx_q <= idx_d;
    end
  end

  assign nxt_mag = mag_d;
  assign nxt_idx = idx_d;
endmodule

// File: rtl/fft_peak_tracker.sv
// Per-frame FFT magnitude peak finder with frame-format checking.
// Define FFT_PEAK_DC_SKIP_EN to exclude bin 0 (DC) from the peak search.
module fft_peak_tracker
  import fft_peak_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int N_BINS = DEF_N_BINS,
  localparam int IDX_W  = $clog2(N_BINS)
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [DATA_W-1:0] in_mag,
  input  logic [DATA_W-1:0] threshold,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_mag,
  output logic              out_no_peak,
  output logic              out_frame_err,
  output logic              busy
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [1:0]        rst_sync_q;
  logic              out_valid_q, out_frame_err_q, out_no_peak_q;
  logic [IDX_W-1:0]  out_index_q;
  logic [DATA_W-1:0] out_mag_q;

  logic [IDX_W-1:0]  beat_idx;
  logic              sync_ok, cmp_load, cmp_en;
  logic [DATA_W-1:0] cmp_mag, nxt_mag;
  logic [IDX_W-1:0]  cmp_idx, nxt_idx;
  logic [IDX_W-1:0]  sop_idx;

  assign beat_idx = cnt_q + IDX_W'(1);
  assign sync_ok  = rst_sync_q[1];
  assign cmp_load = in_valid && in_sop && sync_ok;
  assign cmp_en   = in_valid && !in_sop && (state_q == ST_SCAN);

`ifdef FFT_PEAK_DC_SKIP_EN
  // DC bin is seeded as a zero at index 1 so bin 1 wins an all-zero frame.
  assign sop_idx = IDX_W'(1);
  assign cmp_mag = in_sop ? '0 : in_mag;
`else
  assign sop_idx = '0;
  assign cmp_mag = in_mag;
`endif

  assign cmp_idx = cmp_load ? sop_idx : beat_idx;

  fft_peak_cmp #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .load    (cmp_load),
    .en      (cmp_en),
    .mag     (cmp_mag),
    .idx     (cmp_idx),
    .nxt_mag (nxt_mag),
    .nxt_idx (nxt_idx)
  );

  // Reset asserts asynchronously; release walks through rst_sync_q before a frame may start.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      rst_sync_q      <= '0;
      out_valid_q     <= 1'b0;
      out_frame_err_q <= 1'b0;
      out_no_peak_q   <= 1'b0;
      out_index_q     <= '0;
      out_mag_q       <= '0;
    end else begin
      rst_sync_q      <= {rst_sync_q[0], 1'b1};
      out_valid_q     <= 1'b0;
      out_frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_sop && sync_ok) begin
            cnt_q <= '0;
            if (in_eop) out_frame_err_q <= 1'b1;
            else        state_q         <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (in_valid) begin
            if (in_sop) begin
              out_frame_err_q <= 1'b1;
              cnt_q           <= '0;
              if (in_eop) state_q <= ST_IDLE;
            end else if (in_eop && (beat_idx == LAST_IDX)) begin
              out_valid_q   <= 1'b1;
              out_index_q   <= nxt_idx;
              out_mag_q     <= nxt_mag;
              out_no_peak_q <= (nxt_mag < threshold);
              cnt_q         <= '0;
              state_q       <= ST_IDLE;
            end else if (in_eop || (beat_idx == LAST_IDX)) begin
              out_frame_err_q <= 1'b1;
              cnt_q           <= '0;
              state_q         <= ST_IDLE;
            end else begin
              cnt_q <= beat_idx;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid     = out_valid_q;
  assign out_frame_err = out_frame_err_q;
  assign out_index     = out_index_q;
  assign out_mag       = out_mag_q;
  assign out_no_peak   = out_no_peak_q;
  assign busy          = (state_q == ST_SCAN);
endmodule

// File: tb/tb_fft_peak_tracker.sv
// Directed and randomized checks of fft_peak_tracker against a frame-level peak model.
module tb_fft_peak_tracker;
  localparam int DW = 12;
  localparam int NB = 256;
  localparam int IW = 8;

  logic          clk_in = 1'b0;
  logic          reset_n = 1'b1;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [DW-1:0] in_mag = '0, threshold = '0;
  logic          out_valid, out_no_peak, out_frame_err, busy;
  logic [IW-1:0] out_index;
  logic [DW-1:0] out_mag;

  always #5 clk_in = ~clk_in;

  fft_peak_tracker #(.DATA_W(DW), .N_BINS(NB)) dut (
    .clk_in        (clk_in),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_mag        (in_mag),
    .threshold     (threshold),
    .out_valid     (out_valid),
    .out_index     (out_index),
    .out_mag       (out_mag),
    .out_no_peak   (out_no_peak),
    .out_frame_err (out_frame_err),
    .busy          (busy)
  );

  int cmp_cnt = 0, mis_cnt = 0;
  int valid_cnt = 0, err_cnt = 0;
  bit both_seen = 1'b0;
  int gap_pct = 0;
  int v0, e0, hold_idx, hold_mag;
  logic [DW-1:0] fr [NB];

  always @(negedge clk_in) begin
    if (reset_n === 1'b1) begin
      if (out_valid === 1'b1) valid_cnt++;
      if (out_frame_err === 1'b1) err_cnt++;
      if (out_valid === 1'b1 && out_frame_err === 1'b1) both_seen = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] m, input bit s, input bit e);
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0; in_sop = s; in_eop = e; in_mag = DW'($urandom);
      tick();
    end
    in_valid = 1'b1; in_sop = s; in_eop = e; in_mag = m;
    tick();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Peak = first bin holding the largest magnitude among the bins that count.
  function automatic void ref_peak(output int idx, output logic [DW-1:0] mx);
    int lo;
`ifdef FFT_PEAK_DC_SKIP_EN
    lo = 1;
`else
    lo = 0;
`endif
    mx = '0;
    for (int i = lo; i < NB; i++) if (fr[i] > mx) mx = fr[i];
    idx = -1;
    for (int i = lo; i < NB; i++) if (idx < 0 && fr[i] == mx) idx = i;
  endfunction

  task automatic run_frame(input string tag, input logic [DW-1:0] thr, input bit chk_restart);
    int ei;
    logic [DW-1:0] em;
    ref_peak(ei, em);
    threshold = thr;
    for (int i = 0; i < NB; i++) begin
      beat(fr[i], i == 0, i == NB - 1);
      if (chk_restart && i == 0) begin
        check({tag, "_restart_err"}, out_frame_err, 1);
        check({tag, "_restart_busy"}, busy, 1);
      end
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_index"}, out_index, ei);
    check({tag, "_mag"}, out_mag, em);
    check({tag, "_nopeak"}, out_no_peak, (em < thr) ? 1 : 0);
    check({tag, "_err"}, out_frame_err, 0);
    $display("frame %s: index=%0d mag=%0d no_peak=%0d", tag, out_index, out_mag, out_no_peak);
    tick();
    check({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_err", out_frame_err, 0);
    check("rst_busy", busy, 0);
    check("rst_index", out_index, 0);
    check("rst_mag", out_mag, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();

    // Ramp magnitudes
    for (int i = 0; i < NB; i++) fr[i] = DW'(i);
    run_frame("ramp", 10, 0);
    check("ramp_idx_const", out_index, 255);
    check("ramp_mag_const", out_mag, 255);

    // Tie: lowest index wins
    for (int i = 0; i < NB; i++) fr[i] = 7;
    fr[40] = 3000; fr[90] = 3000;
    run_frame("tie", 100, 0);
    check("tie_idx_const", out_index, 40);

    // DC bin handling
    for (int i = 0; i < NB; i++) fr[i] = 0;
    fr[0] = 4000; fr[5] = 50;
    run_frame("dc", 0, 0);
`ifdef FFT_PEAK_DC_SKIP_EN
    check("dc_idx_const", out_index, 5);
    check("dc_mag_const", out_mag, 50);
`else
    check("dc_idx_const", out_index, 0);
    check("dc_mag_const", out_mag, 4000);
`endif

    // Below threshold
    for (int i = 0; i < NB; i++) fr[i] = DW'($urandom_range(79));
    fr[$urandom_range(1, NB - 1)] = 80;
    run_frame("below", 100, 0);
    check("below_nopeak_const", out_no_peak, 1);
    check("below_mag_const", out_mag, 80);

    // Results hold while idle beats without sop are ignored
    hold_idx = out_index; hold_mag = out_mag;
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < 10; i++) beat(DW'($urandom), 1'b0, i == 5);
    check("idle_busy", busy, 0);
    check("idle_strobes", (valid_cnt - v0) + (err_cnt - e0), 0);
    check("hold_index", out_index, hold_idx);
    check("hold_mag", out_mag, hold_mag);

    // Randomized frames with gaps and ties
    gap_pct = 30;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NB; i++) fr[i] = (f % 2 == 0) ? DW'($urandom) : DW'($urandom_range(15));
      run_frame($sformatf("rand%0d", f), DW'($urandom), 0);
    end

    // Early eop, then sop mid-frame, then a good frame
    gap_pct = 20;
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i <= 100; i++) beat(DW'($urandom), i == 0, i == 100);
    check("early_eop_err", out_frame_err, 1);
    check("early_eop_busy", busy, 0);
    for (int i = 0; i < 30; i++) beat(DW'($urandom), i == 0, 1'b0);
    for (int i = 0; i < NB; i++) fr[i] = DW'($urandom);
    run_frame("recover", 500, 1);
    check("recover_valid_cnt", valid_cnt - v0, 1);
    check("recover_err_cnt", err_cnt - e0, 2);

    // Missing eop on the last bin
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < NB; i++) beat(DW'($urandom), i == 0, 1'b0);
    check("no_eop_err", out_frame_err, 1);
    check("no_eop_busy", busy, 0);
    tick();
    check("no_eop_valid_cnt", valid_cnt - v0, 0);
    $display("frame no_eop: err_pulses=%0d", err_cnt - e0);

    // Sop and eop together
    e0 = err_cnt; v0 = valid_cnt;
    beat(DW'(123), 1'b1, 1'b1);
    check("short_err", out_frame_err, 1);
    check("short_busy", busy, 0);
    tick();
    check("short_err_cnt", err_cnt - e0, 1);
    check("short_valid_cnt", valid_cnt - v0, 0);

    // Reset mid-frame
    gap_pct = 40;
    v0 = valid_cnt; e0 = err_cnt;
    for (int i = 0; i < NB; i++) fr[i] = DW'($urandom);
    for (int i = 0; i < 120; i++) beat(fr[i], i == 0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_index", out_index, 0);
    check("midrst_mag", out_mag, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    run_frame("after_rst", 50, 0);
    tick();
    check("after_rst_valid_cnt", valid_cnt - v0, 1);
    check("after_rst_err_cnt", err_cnt - e0, 0);

    check("never_both", both_seen, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end
endmodule
